// File: rtl/bit_rev_deser_pkg.sv
// Shared types for the bit-reversing deserializer and its companion serializer.
package bit_rev_deser_pkg;

  typedef enum logic {
    RECV = 1'b0,
    HOLD = 1'b1
  } deser_state_e;

  // Counter width able to hold the values 0..n
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/bit_rev_deser_bit_counter.sv
// Accepted-bit counter: counts up on en, clear wins over en; last flags index nbits-1.
module bit_counter
  import bit_rev_deser_pkg::*;
#(
  parameter int unsigned nbits = 8,
  localparam int unsigned CW = cnt_width(nbits)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          clear,
  output logic [CW-1:0] count,
  output logic          last
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign last  = (count_q == CW'(nbits - 1));

endmodule

// File: rtl/bit_rev_deser.sv
// Serial-to-parallel converter: the k-th accepted bit lands in out[k], so an
// MSB-first stream appears bit-reversed on out.
module bit_rev_deser
  import bit_rev_deser_pkg::*;
#(
  parameter int unsigned nbits = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic             in_,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [nbits-1:0] out
);

  localparam int unsigned CW = cnt_width(nbits);

  deser_state_e     state_q;
  deser_state_e     state_d;
  logic [nbits-1:0] data_q;
  logic [nbits-1:0] data_d;
  logic [CW-1:0]    cnt;
  logic             cnt_last;
  logic             bit_xfer;
  logic             cnt_clear;

  assign bit_xfer  = in_val && in_rdy;
  // The counter is 0 throughout HOLD, so last can only fire in RECV
  assign cnt_clear = bit_xfer && cnt_last;

  bit_counter #(
    .nbits(nbits)
  ) u_bit_counter (
    .clk  (clk),
    .reset(reset),
    .en   (bit_xfer),
    .clear(cnt_clear),
    .count(cnt),
    .last (cnt_last)
  );

  always_comb begin
    state_d = state_q;
    in_rdy  = 1'b1;
    out_val = 1'b0;
    case (state_q)
      RECV: begin
        if (cnt_clear) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        out_val = 1'b1;
        in_rdy  = out_rdy;
        // A word transfer always releases HOLD; any concurrent bit starts the next word
        if (out_rdy) begin
          state_d = RECV;
        end
      end
      default: state_d = RECV;
    endcase
  end

  always_comb begin
    data_d = data_q;
    if (bit_xfer) begin
      for (int unsigned i = 0; i < nbits; i++) begin
        if (CW'(i) == cnt) begin
          data_d[i] = in_;
        end else if (cnt == '0) begin
          data_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RECV;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign out = data_q;

endmodule

// File: tb/tb_bit_rev_deser.sv
// Randomized self-checking bench for bit_rev_deser at nbits=8 and nbits=13.
module tb_bit_rev_deser;

  logic        clk = 1'b0;
  logic        reset;
  int          sel;
  logic        cur_v, cur_d, cur_r;

  logic        v8, d8, r8, v13, d13, r13;
  logic        in_rdy8, out_val8, in_rdy13, out_val13;
  logic [7:0]  out8;
  logic [12:0] out13;

  logic        obs_rdy, obs_val;
  logic [63:0] obs_out;

  int          checks = 0;
  int          errors = 0;

  logic [63:0] tx_q[$];
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  assign v8  = (sel == 8)  ? cur_v : 1'b0;
  assign d8  = (sel == 8)  ? cur_d : 1'b0;
  assign r8  = (sel == 8)  ? cur_r : 1'b0;
  assign v13 = (sel == 13) ? cur_v : 1'b0;
  assign d13 = (sel == 13) ? cur_d : 1'b0;
  assign r13 = (sel == 13) ? cur_r : 1'b0;

  assign obs_rdy = (sel == 13) ? in_rdy13 : in_rdy8;
  assign obs_val = (sel == 13) ? out_val13 : out_val8;
  assign obs_out = (sel == 13) ? {51'b0, out13} : {56'b0, out8};

  bit_rev_deser #(.nbits(8)) u_dut8 (
    .clk(clk), .reset(reset), .in_val(v8), .in_rdy(in_rdy8), .in_(d8),
    .out_val(out_val8), .out_rdy(r8), .out(out8)
  );

  bit_rev_deser #(.nbits(13)) u_dut13 (
    .clk(clk), .reset(reset), .in_val(v13), .in_rdy(in_rdy13), .in_(d13),
    .out_val(out_val13), .out_rdy(r13), .out(out13)
  );

  function automatic logic [63:0] rev(input logic [63:0] w, input int n);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r[k] = w[n-1-k];
    return r;
  endfunction

  // Scoreboard driver: val_mode 0=always 1=alternate 2=random; rdy_mode 0=always 1=random 2=stall
  task automatic run_words(input int n, input int val_mode, input int rdy_mode,
                           input int stall_cycles, output int send_cycle);
    int bi, cycles, stalled;
    logic exp_val, exp_rdy, bx, wx;
    bi = 0; cycles = 0; stalled = 0; send_cycle = -1;
    while ((tx_q.size() > 0 || exp_q.size() > 0) && cycles < 5000) begin
      @(negedge clk);
      if (tx_q.size() == 0) cur_v = 1'b0;
      else if (val_mode == 0) cur_v = 1'b1;
      else if (val_mode == 1) cur_v = (cycles % 2 == 0);
      else cur_v = 1'($urandom_range(0, 1));
      cur_d = (tx_q.size() > 0) ? tx_q[0][n-1-bi] : 1'b0;
      if (rdy_mode == 0) cur_r = 1'b1;
      else if (rdy_mode == 1) cur_r = 1'($urandom_range(0, 1));
      else if (exp_q.size() > 0 && stalled < stall_cycles) begin
        cur_r = 1'b0; stalled++;
      end else cur_r = 1'b1;
      #1;
      exp_val = (exp_q.size() != 0);
      exp_rdy = !exp_val || cur_r;
      checks++;
      if (obs_val !== exp_val) begin
        errors++; $display("FAIL out_val n=%0d cyc=%0d: got %b want %b", n, cycles, obs_val, exp_val);
      end
      checks++;
      if (obs_rdy !== exp_rdy) begin
        errors++; $display("FAIL in_rdy n=%0d cyc=%0d: got %b want %b", n, cycles, obs_rdy, exp_rdy);
      end
      if (exp_val) begin
        checks++;
        if (obs_out !== exp_q[0]) begin
          errors++; $display("FAIL out n=%0d cyc=%0d: got %h want %h", n, cycles, obs_out, exp_q[0]);
        end
      end
      bx = cur_v && exp_rdy;
      wx = exp_val && cur_r;
      @(posedge clk);
      if (wx) void'(exp_q.pop_front());
      if (bx) begin
        bi++;
        if (bi == n) begin
          exp_q.push_back(rev(tx_q.pop_front(), n));
          bi = 0;
          if (tx_q.size() == 0) send_cycle = cycles + 1;
        end
      end
      cycles++;
    end
    checks++;
    if (tx_q.size() != 0 || exp_q.size() != 0) begin
      errors++; $display("FAIL timeout n=%0d: got %0d pending want 0", n, tx_q.size() + exp_q.size());
      tx_q.delete(); exp_q.delete();
    end
    @(negedge clk);
    cur_v = 1'b0; cur_r = 1'b0; cur_d = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; cur_v = 1'b1; cur_r = 1'b1; cur_d = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (obs_rdy !== 1'b1 || obs_val !== 1'b0 || obs_out !== 64'd0) begin
      errors++; $display("FAIL reset_outputs sel=%0d: got rdy=%b val=%b out=%h want 1 0 0",
                         sel, obs_rdy, obs_val, obs_out);
    end
    @(negedge clk);
    reset = 1'b0; cur_v = 1'b0; cur_r = 1'b0; cur_d = 1'b0;
    #1;
    checks++;
    if (obs_rdy !== 1'b1 || obs_val !== 1'b0 || obs_out !== 64'd0) begin
      errors++; $display("FAIL post_reset sel=%0d: got rdy=%b val=%b out=%h want 1 0 0",
                         sel, obs_rdy, obs_val, obs_out);
    end
  endtask

  task automatic test_reset();
    sel = 0; reset = 1'b1; cur_v = 1'b0; cur_r = 1'b0; cur_d = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_rdy8 !== 1'b1 || out_val8 !== 1'b0 || out8 !== 8'd0) begin
      errors++; $display("FAIL reset8: got rdy=%b val=%b out=%h want 1 0 00", in_rdy8, out_val8, out8);
    end
    checks++;
    if (in_rdy13 !== 1'b1 || out_val13 !== 1'b0 || out13 !== 13'd0) begin
      errors++; $display("FAIL reset13: got rdy=%b val=%b out=%h want 1 0 0000", in_rdy13, out_val13, out13);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single_word();
    int sc;
    sel = 8;
    tx_q.push_back(64'h01);
    run_words(8, 0, 0, 0, sc);
  endtask

  task automatic test_back_to_back();
    int sc;
    sel = 8;
    tx_q.push_back(64'h88);
    tx_q.push_back(64'h22);
    run_words(8, 0, 0, 0, sc);
    checks++;
    if (sc != 16) begin
      errors++; $display("FAIL back_to_back_cycles: got %0d want 16", sc);
    end
  endtask

  task automatic test_gaps();
    int sc;
    sel = 13;
    tx_q.push_back(64'h1555);
    run_words(13, 1, 0, 0, sc);
  endtask

  task automatic test_stall();
    int sc;
    sel = 8;
    tx_q.push_back(64'hA7);
    tx_q.push_back(64'h3C);
    tx_q.push_back(64'hF0);
    run_words(8, 0, 2, 5, sc);
  endtask

  task automatic test_reset_midword();
    int sc;
    logic [12:0] w;
    sel = 13;
    w = 13'($urandom);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      cur_v = 1'b1; cur_r = 1'b0; cur_d = w[12-k];
    end
    do_reset();
    tx_q.push_back(64'h1fff);
    run_words(13, 0, 0, 0, sc);
  endtask

  task automatic test_reset_hold();
    logic [7:0] w;
    sel = 8;
    w = 8'($urandom);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      cur_v = 1'b1; cur_r = 1'b0; cur_d = w[7-k];
    end
    @(negedge clk);
    cur_v = 1'b0;
    #1;
    checks++;
    if (obs_val !== 1'b1 || obs_out !== rev({56'b0, w}, 8)) begin
      errors++; $display("FAIL hold_word: got val=%b out=%h want 1 %h", obs_val, obs_out, rev({56'b0, w}, 8));
    end
    do_reset();
  endtask

  task automatic test_random();
    int sc;
    sel = 8;
    for (int i = 0; i < 20; i++) tx_q.push_back({56'b0, 8'($urandom)});
    run_words(8, 2, 1, 0, sc);
    sel = 13;
    for (int i = 0; i < 20; i++) tx_q.push_back({51'b0, 13'($urandom)});
    run_words(13, 2, 1, 0, sc);
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_gaps();
    test_stall();
    test_reset_midword();
    test_reset_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
